// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator.
// Turns single-beat host commands (valid/ready) into one bus cycle each and
// returns the read data, or an all-ones word with an error flag when no ack
// arrives in time. After every response it waits for the slave to release
// ack before taking the next command. This keeps a slave that holds ack for
// a few cycles after stb drops from completing the following cycle early.
module wb_initiator #(
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [3:0]  SEL_DEFAULT = 4'hF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // host command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  // host response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  // wishbone master port
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Last timer value before giving up. The timer clears on entry to BUS and
  // to DRAIN, so reaching this value means TIMEOUT cycles spent in the state.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic        timer_done;
  logic        cmd_ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_dat_q;
  logic        rsp_err_q;
  logic [31:0] wbm_adr_q;
  logic [31:0] wbm_dat_q;
  logic        wbm_we_q;
  logic        wbm_cyc_q;
  logic        wbm_stb_q;

  // Saturating timer increment and the "out of patience" flag.
  always_comb begin
    timer_d    = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    timer_done = (timer_q == TIMER_LAST);
  end

  // Control FSM; all host and bus outputs are registered here.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      wbm_adr_q   <= 32'd0;
      wbm_dat_q   <= 32'd0;
      wbm_we_q    <= 1'b0;
      wbm_cyc_q   <= 1'b0;
      wbm_stb_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            wbm_adr_q   <= cmd_adr;
            wbm_dat_q   <= cmd_dat;
            wbm_we_q    <= cmd_we;
            wbm_cyc_q   <= 1'b1;
            wbm_stb_q   <= 1'b1;
            timer_q     <= 16'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= BUS;
          end
        end

        BUS: begin
          if (wbm_ack_i) begin
            rsp_dat_q   <= wbm_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            wbm_cyc_q   <= 1'b0;
            wbm_stb_q   <= 1'b0;
            wbm_we_q    <= 1'b0;
            state_q     <= RESP;
          end else if (timer_done) begin
            rsp_dat_q   <= 32'hFFFF_FFFF;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            wbm_cyc_q   <= 1'b0;
            wbm_stb_q   <= 1'b0;
            wbm_we_q    <= 1'b0;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_d;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            timer_q     <= 16'd0;
            state_q     <= DRAIN;
          end
        end

        DRAIN: begin
          if (!wbm_ack_i || timer_done) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          wbm_cyc_q   <= 1'b0;
          wbm_stb_q   <= 1'b0;
          wbm_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_adr_o = wbm_adr_q;
  assign wbm_dat_o = wbm_dat_q;
  assign wbm_we_o  = wbm_we_q;
  assign wbm_cyc_o = wbm_cyc_q;
  assign wbm_stb_o = wbm_stb_q;
  assign wbm_sel_o = SEL_DEFAULT;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator with TIMEOUT = 8.
// The bench plays the slave by hand: each task sets ack/data in the cycle
// it wants them sampled. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_wb_initiator;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wb_initiator #(.TIMEOUT(TMO), .SEL_DEFAULT(4'hF)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .busy      (busy)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly the accepting edge.
  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp: got valid=%b err=%b dat=%h expected 0/0/0", rsp_valid, rsp_err, rsp_dat); end
    checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_bus_ctrl: got cyc/stb/we/busy=%b expected 0000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy}); end
    checks++; if (wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_adr_dat: got adr=%h dat=%h expected 0/0", wbm_adr_o, wbm_dat_o); end
    checks++; if (wbm_sel_o !== 4'hF) begin errors++; $display("[TB] FAIL sel_default: got %h expected F", wbm_sel_o); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: got ready=%b busy=%b expected 1/0", cmd_ready, busy); end
  endtask

  // Write; slave acks in the second stb cycle and holds ack for 2 cycles.
  task automatic test_write();
    int cyc_cnt;
    rsp_ready = 1'b1;
    issue_cmd(1'b1, 32'h3080_0000, 32'h0000_0011);
    cyc_cnt = 0;
    checks++; if (wbm_we_o !== 1'b1 || wbm_adr_o !== 32'h3080_0000 || wbm_dat_o !== 32'h0000_0011) begin errors++; $display("[TB] FAIL write_bus_fields: got we=%b adr=%h dat=%h expected 1/30800000/00000011", wbm_we_o, wbm_adr_o, wbm_dat_o); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy: got ready=%b busy=%b expected 0/1", cmd_ready, busy); end
    if (wbm_cyc_o && wbm_stb_o) cyc_cnt++;
    tick();
    if (wbm_cyc_o && wbm_stb_o) cyc_cnt++;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL write_rsp_early: got %b expected 0", rsp_valid); end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0000_0055;
    tick();
    if (wbm_cyc_o && wbm_stb_o) cyc_cnt++;
    // Counting accept cycle, two stb cycles, then response cycle: 4th cycle.
    checks++; if (cyc_cnt !== 2) begin errors++; $display("[TB] FAIL write_cyc_len: got %0d cycles expected 2", cyc_cnt); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0000_0055) begin errors++; $display("[TB] FAIL write_rsp: got valid=%b err=%b dat=%h expected 1/0/00000055", rsp_valid, rsp_err, rsp_dat); end
    checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("[TB] FAIL write_we_drop: got %b expected 0", wbm_we_o); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL write_drain_wait: got valid=%b ready=%b expected 0/0", rsp_valid, cmd_ready); end
    wbm_ack_i = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL write_back_idle: got ready=%b busy=%b expected 1/0", cmd_ready, busy); end
  endtask

  // Read with data; response is held back by rsp_ready for 5 cycles.
  task automatic test_read_hold();
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 32'h3000_0004, 32'h0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL read_rsp: got valid=%b err=%b dat=%h expected 1/0/deadbeef", rsp_valid, rsp_err, rsp_dat); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL read_hold_%0d: got valid=%b dat=%h expected 1/deadbeef", i, rsp_valid, rsp_dat); end
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL read_consume: got %b expected 0", rsp_valid); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL read_back_idle: got %b expected 1", cmd_ready); end
  endtask

  // No ack at all: cyc/stb for exactly TMO cycles, then error response.
  task automatic test_timeout();
    int cyc_cnt;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    issue_cmd(1'b1, 32'h3080_0010, 32'h1234_0000);
    cyc_cnt = 0;
    for (int i = 0; i < 20 && wbm_cyc_o === 1'b1; i++) begin
      if (wbm_stb_o === 1'b1) cyc_cnt++;
      tick();
    end
    checks++; if (cyc_cnt !== TMO) begin errors++; $display("[TB] FAIL timeout_cyc_len: got %0d cycles expected %0d", cyc_cnt, TMO); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL timeout_rsp: got valid=%b err=%b dat=%h expected 1/1/ffffffff", rsp_valid, rsp_err, rsp_dat); end
    tick();
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_wait_consume: got ready=%b valid=%b expected 0/1", cmd_ready, rsp_valid); end
    rsp_ready = 1'b1;
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL timeout_back_idle: got %b expected 1", cmd_ready); end
  endtask

  // Ack first appears in the last BUS cycle: ack wins over timeout.
  task automatic test_ack_on_timeout();
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 32'h3080_0020, 32'h0);
    for (int i = 0; i < TMO - 1; i++) tick();
    checks++; if (wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_tmo_still_bus: got cyc=%b valid=%b expected 1/0", wbm_cyc_o, rsp_valid); end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hA5A5_1234;
    tick();
    wbm_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hA5A5_1234) begin errors++; $display("[TB] FAIL ack_tmo_rsp: got valid=%b err=%b dat=%h expected 1/0/a5a51234", rsp_valid, rsp_err, rsp_dat); end
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL ack_tmo_back_idle: got %b expected 1", cmd_ready); end
  endtask

  // Ack lingers 3 cycles past the response while the next command waits.
  task automatic test_lingering_ack();
    rsp_ready = 1'b1;
    issue_cmd(1'b1, 32'h3080_0004, 32'h0000_0022);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0000_0011;
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL linger_first_rsp: got %b expected 1", rsp_valid); end
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3080_0008;
    cmd_dat   = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL linger_blocked_%0d: got ready=%b cyc=%b valid=%b expected 0/0/0", i, cmd_ready, wbm_cyc_o, rsp_valid); end
    end
    wbm_ack_i = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL linger_release: got ready=%b cyc=%b expected 1/0", cmd_ready, wbm_cyc_o); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3080_0008 || wbm_we_o !== 1'b0) begin errors++; $display("[TB] FAIL linger_second_start: got cyc=%b adr=%h we=%b expected 1/30800008/0", wbm_cyc_o, wbm_adr_o, wbm_we_o); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL linger_waits_fresh_ack: got valid=%b cyc=%b expected 0/1", rsp_valid, wbm_cyc_o); end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0000_0077;
    tick();
    wbm_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0000_0077) begin errors++; $display("[TB] FAIL linger_second_rsp: got valid=%b dat=%h expected 1/00000077", rsp_valid, rsp_dat); end
    tick();
    tick();
    // Stray ack pulse while idle must not produce a response.
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_stray_ack_%0d: got valid=%b busy=%b ready=%b expected 0/0/1", i, rsp_valid, busy, cmd_ready); end
    end
    wbm_ack_i = 1'b0;
    tick();
  endtask

  // Reset between edges in BUS drops the cycle at once; next command works.
  task automatic test_reset_in_bus();
    rsp_ready = 1'b1;
    issue_cmd(1'b1, 32'h3080_0030, 32'hCAFE_0000);
    tick();
    checks++; if (wbm_cyc_o !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_bus_pre: got cyc=%b busy=%b expected 1/1", wbm_cyc_o, busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_async: got cyc=%b stb=%b valid=%b busy=%b ready=%b expected 0/0/0/0/1", wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready); end
    rst = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_no_rsp: got valid=%b ready=%b expected 0/1", rsp_valid, cmd_ready); end
    issue_cmd(1'b0, 32'h3080_0034, 32'h0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    tick();
    wbm_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rst_next_cmd: got valid=%b err=%b dat=%h expected 1/0/12345678", rsp_valid, rsp_err, rsp_dat); end
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_next_idle: got %b expected 1", cmd_ready); end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'd0;
    cmd_dat   = 32'd0;
    rsp_ready = 1'b0;
    wbm_dat_i = 32'd0;
    wbm_ack_i = 1'b0;
    test_reset();
    test_write();
    test_read_hold();
    test_timeout();
    test_ack_on_timeout();
    test_lingering_ack();
    test_reset_in_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic-cycle master. Converts single-beat commands from a host-side valid/ready port into bus cycles and returns read data or a timeout error on a response port.
- Drives the caravel-side Wishbone slaves in this design, such as the design multiplexer's control and SRAM window. Used for bring-up and test sequencing without the management core.
- Handles slaves that hold ack for several cycles after stb drops; this is the multiplexer's two-stage ack delay.

Parameters:
- TIMEOUT, 64, max cycles to wait for ack in BUS or for ack release in DRAIN; legal range 2..65535.
- SEL_DEFAULT, 4'hF, value driven on wbm_sel_o for every cycle.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready at a rising edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_dat  out  32  read data (writes: last wbm_dat_i sampled with ack)
- rsp_err  out  1  1 = timeout, no ack
- wbm_adr_o  out  32  bus address
- wbm_dat_o  out  32  bus write data
- wbm_dat_i  in  32  bus read data
- wbm_we_o  out  1  bus write enable
- wbm_sel_o  out  4  byte selects
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_ack_i  in  1  slave ack
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate on wb_rst_i):
  - state = IDLE; cmd_ready = 1.
  - rsp_valid = 0, rsp_dat = 0, rsp_err = 0.
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 0; wbm_adr_o = 0, wbm_dat_o = 0.
  - Timer = 0; busy = 0.
  - Reset mid-cycle drops cyc/stb immediately. No response is produced for the aborted command.
- All outputs are registered. wbm_sel_o = SEL_DEFAULT constant.
- States: IDLE, BUS, RESP, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch adr/dat/we into wbm_* and assert cyc = stb = 1 the next cycle. Timer clears; go BUS.
  - wbm_ack_i is ignored in IDLE.
- BUS:
  - cmd_ready = 0. Timer increments each cycle.
  - If ack_i = 1 is sampled: rsp_dat <= wbm_dat_i, rsp_err <= 0, cyc = stb = we = 0 next cycle, rsp_valid <= 1, go RESP.
  - Else if timer == TIMEOUT-1: rsp_dat <= 32'hFFFFFFFF, rsp_err <= 1, drop cyc/stb/we, rsp_valid <= 1, go RESP.
  - Ack has priority over timeout when both occur in the same cycle.
  - Minimum command-accept-to-rsp_valid latency = 1 + slave ack latency + 1 cycles. Against the multiplexer (ack 2 cycles after stb): 4 cycles.
- RESP:
  - rsp_valid held, with rsp_dat/rsp_err stable, until rsp_ready is sampled high.
  - Then rsp_valid <= 0, timer clears, go DRAIN.
  - rsp_ready = 1 on the first RESP cycle is legal: a one-cycle response.
- DRAIN:
  - cyc = stb = 0. Wait until ack_i is sampled 0, then go IDLE with cmd_ready <= 1.
  - If ack_i stays high for TIMEOUT cycles, go IDLE anyway; no error is reported.
  - This guarantees a lingering ack from a slow-releasing slave is never taken as the ack of the next command.
- A stray ack in IDLE, RESP, or DRAIN never produces a response.
- cmd_* are sampled only at accept. Later changes have no effect on the cycle in flight.
- Timer width is 16 bits with no wrap. TIMEOUT = 2 gives a timeout on the second BUS cycle.

Test Plan:
- Write, slave acks 2 cycles after stb for 2 cycles:
  - Command adr = 32'h3080_0000, dat = 32'h0000_0011, we = 1.
  - wbm_we_o = 1 and cyc/stb are high for exactly 2 cycles.
  - rsp_valid rises 4 cycles after accept with rsp_err = 0.
  - Next cmd_ready waits until ack_i = 0.
- Read with data: slave acks with wbm_dat_i = 32'hDEADBEEF → rsp_dat = 32'hDEADBEEF, rsp_err = 0. Hold rsp_ready = 0 for 5 cycles: rsp_valid and rsp_dat are stable throughout.
- Timeout: no ack, TIMEOUT = 8 → cyc/stb high for exactly 8 cycles, then rsp_err = 1, rsp_dat = 32'hFFFFFFFF, and cmd_ready returns after the response is consumed.
- Ack on the timeout cycle: ack first sampled at timer == TIMEOUT-1 → rsp_err = 0 and rsp_dat = bus data.
- Lingering ack:
  - After a response, ack_i is held high 3 more cycles while a new cmd_valid waits.
  - cmd_ready stays 0 until ack_i is low; the second command's cycle begins only then and takes a fresh ack.
  - Also inject an ack pulse in IDLE: no rsp_valid.
- Async reset in BUS: assert wb_rst_i mid-cycle → cyc/stb/rsp_valid fall with no clock edge. After release, cmd_ready = 1 and the next command completes normally.
